// File: rtl/ecg_moving_avg_pkg.sv
// Shared constants and types for the ECG moving-average stage.
// The window sizes here fix the sum widths and the average shift amounts used by the top.
package ecg_moving_avg_pkg;

    localparam int DATA_WIDTH  = 11;
    localparam int CTR_WIDTH   = 22;
    localparam int NAVG_SHORT  = 16;
    localparam int NAVG_LONG   = 32;
    localparam int DATA_OFFSET = 1024;

    localparam int AVG_S_SHIFT = $clog2(NAVG_SHORT);
    localparam int AVG_L_SHIFT = $clog2(NAVG_LONG);
    localparam int SUM_S_W     = DATA_WIDTH + AVG_S_SHIFT;
    localparam int SUM_L_W     = DATA_WIDTH + AVG_L_SHIFT;
    localparam int PTR_W       = AVG_L_SHIFT;
    localparam int FILL_W      = AVG_L_SHIFT + 1;

    typedef logic [DATA_WIDTH-1:0]        ecg_sample;
    typedef logic [CTR_WIDTH-1:0]         sample_num;
    typedef logic signed [DATA_WIDTH-1:0] ecg_centred;

    typedef struct packed {
        ecg_centred sample;
        ecg_centred avg_short;
        ecg_centred avg_long;
        sample_num  num;
        logic       short_full;
        logic       long_full;
    } ecg_avg_t;

    // DATA_OFFSET is 2^(DATA_WIDTH-1), so the subtraction reduces to an MSB flip.
    function automatic ecg_centred centre(input ecg_sample s);
        return {~s[DATA_WIDTH-1], s[DATA_WIDTH-2:0]};
    endfunction

endpackage

// File: rtl/ecg_moving_avg_window_buf.sv
// Circular window of the last NAVG_LONG centred samples.
// Two combinational taps expose the oldest entry of the long and of the short window.
module ecg_window_buf
    import ecg_moving_avg_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    input  logic                  i_we,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic [DATA_WIDTH-1:0] o_tap_long,
    output logic [DATA_WIDTH-1:0] o_tap_short
);

    logic [PTR_W-1:0]      r_ptr;
    logic [DATA_WIDTH-1:0] r_buf [NAVG_LONG];
    logic [PTR_W-1:0]      w_ptr_short;

    // Pointer arithmetic wraps modulo NAVG_LONG because PTR_W = log2(NAVG_LONG).
    assign w_ptr_short = r_ptr - PTR_W'(NAVG_SHORT);
    assign o_tap_long  = r_buf[r_ptr];
    assign o_tap_short = r_buf[w_ptr_short];

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_ptr <= '0;
            for (int i = 0; i < NAVG_LONG; i++) r_buf[i] <= '0;
        end else if (i_we) begin
            r_buf[r_ptr] <= i_wr_data;
            r_ptr        <= r_ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/ecg_moving_avg.sv
// Centres raw ECG samples and produces short/long running averages with a sample number.
// Output bundle is registered; the valid/ready handshake sustains one sample per cycle.
module ecg_moving_avg
    import ecg_moving_avg_pkg::*;
#(
    parameter int CTR_W = CTR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] in_sample,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_sample,
    output logic [DATA_WIDTH-1:0] out_avg_short,
    output logic [DATA_WIDTH-1:0] out_avg_long,
    output logic [CTR_W-1:0]      out_num,
    output logic                  out_short_full,
    output logic                  out_long_full,
    output logic                  out_valid,
    input  logic                  out_ready
);

    ecg_avg_t                    r_out;
    logic                        r_out_valid;
    logic signed [SUM_S_W-1:0]   r_sum_s;
    logic signed [SUM_L_W-1:0]   r_sum_l;
    logic [CTR_W-1:0]            r_cnt;
    logic [FILL_W-1:0]           r_fill;

    logic                        w_accept;
    ecg_centred                  w_c;
    logic [DATA_WIDTH-1:0]       w_tap_l;
    logic [DATA_WIDTH-1:0]       w_tap_s;
    logic signed [SUM_S_W-1:0]   w_c_s, w_old_s, w_sum_s_nxt;
    logic signed [SUM_L_W-1:0]   w_c_l, w_old_l, w_sum_l_nxt;
    logic [FILL_W-1:0]           w_fill_nxt;
    ecg_centred                  w_avg_s, w_avg_l;

    assign in_ready = !rst && !clear && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_c      = centre(in_sample);

    ecg_window_buf u_buf (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (clear),
        .i_we        (w_accept),
        .i_wr_data   (w_c),
        .o_tap_long  (w_tap_l),
        .o_tap_short (w_tap_s)
    );

    // Signed assignments sign-extend the centred values to the sum widths.
    assign w_c_s       = w_c;
    assign w_c_l       = w_c;
    assign w_old_s     = $signed(w_tap_s);
    assign w_old_l     = $signed(w_tap_l);
    assign w_sum_s_nxt = r_sum_s + w_c_s - w_old_s;
    assign w_sum_l_nxt = r_sum_l + w_c_l - w_old_l;

    // Arithmetic shift floors toward -inf; the quotient always fits DATA_WIDTH.
    assign w_avg_s    = ecg_centred'(w_sum_s_nxt >>> AVG_S_SHIFT);
    assign w_avg_l    = ecg_centred'(w_sum_l_nxt >>> AVG_L_SHIFT);
    assign w_fill_nxt = (r_fill == FILL_W'(NAVG_LONG)) ? r_fill : r_fill + FILL_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_sum_s     <= '0;
            r_sum_l     <= '0;
            r_cnt       <= '0;
            r_fill      <= '0;
        end else if (clear) begin
            r_out_valid <= 1'b0;
            r_sum_s     <= '0;
            r_sum_l     <= '0;
            r_cnt       <= '0;
            r_fill      <= '0;
        end else if (w_accept) begin
            r_sum_s            <= w_sum_s_nxt;
            r_sum_l            <= w_sum_l_nxt;
            r_cnt              <= r_cnt + CTR_W'(1);
            r_fill             <= w_fill_nxt;
            r_out.sample       <= w_c;
            r_out.avg_short    <= w_avg_s;
            r_out.avg_long     <= w_avg_l;
            r_out.num          <= sample_num'(r_cnt);
            r_out.short_full   <= (w_fill_nxt >= FILL_W'(NAVG_SHORT));
            r_out.long_full    <= (w_fill_nxt >= FILL_W'(NAVG_LONG));
            r_out_valid        <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_sample     = r_out.sample;
    assign out_avg_short  = r_out.avg_short;
    assign out_avg_long   = r_out.avg_long;
    assign out_num        = r_out.num[CTR_W-1:0];
    assign out_short_full = r_out.short_full;
    assign out_long_full  = r_out.long_full;
    assign out_valid      = r_out_valid;

endmodule

// File: tb/tb_ecg_moving_avg.sv
// Self-checking bench: a history-queue model checked every cycle, plus literal expectations.
// A second instance with a 6-bit counter exercises the sample-number wrap.
module tb_ecg_moving_avg;

    logic        clk = 1'b0;
    logic        rst, clear, in_valid, out_ready;
    logic [10:0] in_sample;
    logic        in_ready, out_short_full, out_long_full, out_valid;
    logic [10:0] out_sample, out_avg_short, out_avg_long;
    logic [21:0] out_num;
    logic        in_ready2, sf2, lf2, ov2;
    logic [10:0] os2, oas2, oal2;
    logic [5:0]  on2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ecg_moving_avg dut (
        .clk(clk), .rst(rst), .clear(clear), .in_sample(in_sample), .in_valid(in_valid),
        .in_ready(in_ready), .out_sample(out_sample), .out_avg_short(out_avg_short),
        .out_avg_long(out_avg_long), .out_num(out_num), .out_short_full(out_short_full),
        .out_long_full(out_long_full), .out_valid(out_valid), .out_ready(out_ready)
    );

    ecg_moving_avg #(.CTR_W(6)) dut2 (
        .clk(clk), .rst(rst), .clear(clear), .in_sample(in_sample), .in_valid(in_valid),
        .in_ready(in_ready2), .out_sample(os2), .out_avg_short(oas2),
        .out_avg_long(oal2), .out_num(on2), .out_short_full(sf2),
        .out_long_full(lf2), .out_valid(ov2), .out_ready(out_ready)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic int fdiv(input int s, input int n);
        if (s >= 0) return s / n;
        return -((-s + n - 1) / n);
    endfunction

    // Model: samples since the last reset/clear, windowed sums taken straight from history.
    int hist[$];
    bit m_valid = 1'b0, m_zero = 1'b1;
    int m_cnt = 0;
    int e_samp = 0, e_s = 0, e_l = 0, e_num = 0, e_sf = 0, e_lf = 0;

    initial forever begin
        bit acc;
        int ss, sl, n;
        @(posedge clk);
        acc = in_valid && !rst && !clear && (!m_valid || out_ready);
        if (rst || clear) begin
            hist.delete();
            m_cnt = 0;
            m_valid = 1'b0;
            if (rst) begin
                m_zero = 1'b1;
                e_samp = 0; e_s = 0; e_l = 0; e_num = 0; e_sf = 0; e_lf = 0;
            end
        end else if (acc) begin
            hist.push_back(int'(in_sample) - 1024);
            if (hist.size() > 32) void'(hist.pop_front());
            n = hist.size();
            ss = 0; sl = 0;
            for (int k = 0; k < n; k++) begin
                sl += hist[n-1-k];
                if (k < 16) ss += hist[n-1-k];
            end
            e_samp = hist[n-1];
            e_s    = fdiv(ss, 16);
            e_l    = fdiv(sl, 32);
            e_num  = m_cnt;
            m_cnt++;
            e_sf   = (m_cnt >= 16) ? 1 : 0;
            e_lf   = (m_cnt >= 32) ? 1 : 0;
            m_valid = 1'b1;
            m_zero  = 1'b0;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        chk("out_valid", int'(out_valid), int'(m_valid));
        chk("in_ready", int'(in_ready), int'(!rst && !clear && (!m_valid || out_ready)));
        chk("out_valid2", int'(ov2), int'(m_valid));
        chk("in_ready2", int'(in_ready2), int'(in_ready));
        if (m_valid || m_zero) begin
            chk("sample", int'($signed(out_sample)), e_samp);
            chk("avg_short", int'($signed(out_avg_short)), e_s);
            chk("avg_long", int'($signed(out_avg_long)), e_l);
            chk("num", int'(out_num), e_num % (1 << 22));
            chk("short_full", int'(out_short_full), e_sf);
            chk("long_full", int'(out_long_full), e_lf);
            chk("sample2", int'($signed(os2)), e_samp);
            chk("avg_short2", int'($signed(oas2)), e_s);
            chk("avg_long2", int'($signed(oal2)), e_l);
            chk("num2", int'(on2), e_num % 64);
            chk("full2", int'({sf2, lf2}), e_sf * 2 + e_lf);
        end
    end

    // Called at posedge+1; leaves in_valid low at posedge+1 after the accept.
    task automatic send(input int raw);
        int n;
        in_sample = 11'(raw);
        in_valid  = 1'b1;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
        end
        if (n == 50) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_chk(input int raw, input int num, input int samp,
                            input int s, input int l, input int sf, input int lf);
        send(raw);
        @(negedge clk);
        chk("lit_valid", int'(out_valid), 1);
        chk("lit_num", int'(out_num), num);
        chk("lit_sample", int'($signed(out_sample)), samp);
        chk("lit_avg_short", int'($signed(out_avg_short)), s);
        chk("lit_avg_long", int'($signed(out_avg_long)), l);
        chk("lit_short_full", int'(out_short_full), sf);
        chk("lit_long_full", int'(out_long_full), lf);
        @(posedge clk); #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_sample = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_avg_long", int'(out_avg_long), 0);
        chk("rst_num", int'(out_num), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Centerline input: averages stay zero, full flags rise at 15 and 31.
        for (int i = 0; i < 40; i++) begin
            if (i == 14 || i == 15 || i == 30 || i == 31)
                send_chk(1024, i, 0, 0, 0, (i >= 15) ? 1 : 0, (i >= 31) ? 1 : 0);
            else
                send(1024);
        end

        // Step of +512.
        do_clear();
        for (int i = 0; i < 40; i++) begin
            if (i == 8)       send_chk(1536, 8, 512, 288, 144, 0, 0);
            else if (i == 15) send_chk(1536, 15, 512, 512, 256, 1, 0);
            else if (i == 31) send_chk(1536, 31, 512, 512, 512, 1, 1);
            else              send(1536);
        end

        // Negative extreme, then floor rounding of a mostly negative sum.
        do_clear();
        for (int i = 0; i < 32; i++) begin
            if (i == 31) send_chk(0, 31, -1024, -1024, -1024, 1, 1);
            else         send(0);
        end
        send_chk(1025, 32, 1, -960, -992, 1, 1);

        // Backpressure: one accept, then the bundle must hold.
        out_ready = 1'b0;
        in_sample = 11'd1100;
        in_valid  = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready", int'(in_ready), 0);
        chk("bp_valid", int'(out_valid), 1);
        chk("bp_num", int'(out_num), 33);
        chk("bp_sample", int'($signed(out_sample)), 76);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Long stream; the 6-bit instance wraps 63 -> 0.
        for (int i = 34; i < 100; i++) begin
            send(int'($urandom_range(0, 2047)));
            if (i == 63 || i == 64) begin
                @(negedge clk);
                chk("wrap_num", int'(out_num), i);
                chk("wrap_num2", int'(on2), (i == 63) ? 63 : 0);
                @(posedge clk); #1;
            end
        end

        // Clear with a sample on offer.
        do_clear();
        for (int i = 0; i < 21; i++) send(int'($urandom_range(0, 2047)));
        clear = 1'b1; in_valid = 1'b1; in_sample = 11'd1500;
        @(negedge clk);
        chk("clr_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("clr_valid", int'(out_valid), 0);
        @(posedge clk); #1;
        send_chk(1300, 0, 276, 17, 8, 0, 0);

        // Reset mid-stream behaves the same.
        for (int i = 0; i < 21; i++) send(int'($urandom_range(0, 2047)));
        rst = 1'b1; in_valid = 1'b1; in_sample = 11'd1500;
        @(negedge clk);
        chk("rst2_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst2_valid", int'(out_valid), 0);
        chk("rst2_sample", int'(out_sample), 0);
        chk("rst2_num", int'(out_num), 0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        send_chk(1300, 0, 276, 17, 8, 0, 0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
